// File: rtl/sign_pkg.sv
// Shared helpers for signed narrowing / extension: saturation limits and fit check.
package sign_pkg;

  // Widest word the helpers handle; callers zero-pad up to this width.
  localparam int MAX_W = 64;

  // Output register occupancy.
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  // Largest n-bit signed value (0 followed by n-1 ones), right-aligned.
  function automatic logic [MAX_W-1:0] sat_max(input int n);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i < n - 1) r[i] = 1'b1;
    return r;
  endfunction

  // Smallest n-bit signed value (1 followed by n-1 zeros), right-aligned.
  function automatic logic [MAX_W-1:0] sat_min(input int n);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++)
      if (i == n - 1) r[i] = 1'b1;
    return r;
  endfunction

  // An m-bit word fits in n signed bits iff bits [m-1:n-1] all equal.
  function automatic logic fits(input logic [MAX_W-1:0] x, input int m, input int n);
    logic f;
    f = 1'b1;
    for (int i = 0; i < MAX_W; i++)
      if (i >= n - 1 && i < m && x[i] != x[m-1]) f = 1'b0;
    return f;
  endfunction

endpackage

// File: rtl/sign_fit_chk.sv
// Combinational narrowing of an M-bit signed word to N bits (saturate or wrap).
module sign_fit_chk
  import sign_pkg::*;
#(
  parameter int M = 32,
  parameter int N = 12
) (
  input  logic [M-1:0] i_x,
  input  logic         i_sat,
  output logic [N-1:0] o_y,
  output logic         o_ovf
);

  localparam logic [MAX_W-1:0] MAX_V = sat_max(N);
  localparam logic [MAX_W-1:0] MIN_V = sat_min(N);

  logic [MAX_W-1:0] x_ext;
  assign x_ext = {{(MAX_W-M){1'b0}}, i_x};

  // Pick truncated value when it fits or in wrap mode, else clamp by sign.
  always_comb begin
    o_ovf = !fits(x_ext, M, N);
    o_y   = i_x[N-1:0];
    if (o_ovf && i_sat)
      o_y = i_x[M-1] ? MIN_V[N-1:0] : MAX_V[N-1:0];
  end

endmodule

// File: rtl/sign_narrow.sv
// Streaming signed narrowing stage: one-entry output register, valid/ready
// handshake on both sides, saturating overflow counter.
module sign_narrow
  import sign_pkg::*;
#(
  parameter int M     = 32,
  parameter int N     = 12,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [M-1:0]     i_x,
  input  logic             i_sat,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [N-1:0]     o_y,
  output logic             o_ovf,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_ovf_cnt
);

  logic [N-1:0]     nar_y;
  logic             nar_ovf;
  logic             accept;

  logic [0:0]       state_q, state_d;
  logic [N-1:0]     y_q, y_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  sign_fit_chk #(.M(M), .N(N)) u_chk (
    .i_x   (i_x),
    .i_sat (i_sat),
    .o_y   (nar_y),
    .o_ovf (nar_ovf)
  );

  assign o_valid   = (state_q == ST_FULL);
  assign o_ready   = !o_valid || i_ready;
  assign accept    = i_valid && o_ready;
  assign o_y       = y_q;
  assign o_ovf     = ovf_q;
  assign o_ovf_cnt = cnt_q;

  // Next state of output register and overflow counter.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = ST_FULL;
      y_d     = nar_y;
      ovf_d   = nar_ovf;
    end else if (i_ready) begin
      state_d = ST_EMPTY;
    end
    if (accept && nar_ovf && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
    // Clear takes priority over a same-cycle increment.
    if (i_cnt_clr)
      cnt_d = '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_EMPTY;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sign_narrow.sv
// Directed bench for sign_narrow: (32,12), (32,20) and (32,12) with CNT_W=2,
// all driven from one shared input stream.
module tb_sign_narrow;

  logic        i_clk = 1'b0;
  logic        i_rst, i_valid, i_sat, i_ready, i_cnt_clr;
  logic [31:0] i_x;

  logic        a_ready, a_valid, a_ovf;
  logic [11:0] a_y;
  logic [15:0] a_cnt;
  logic        b_ready, b_valid, b_ovf;
  logic [19:0] b_y;
  logic [15:0] b_cnt;
  logic        c_ready, c_valid, c_ovf;
  logic [11:0] c_y;
  logic [1:0]  c_cnt;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  sign_narrow #(.M(32), .N(12), .CNT_W(16)) u_a (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(a_ready),
    .i_x(i_x), .i_sat(i_sat), .o_valid(a_valid), .i_ready(i_ready),
    .o_y(a_y), .o_ovf(a_ovf), .i_cnt_clr(i_cnt_clr), .o_ovf_cnt(a_cnt));

  sign_narrow #(.M(32), .N(20), .CNT_W(16)) u_b (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(b_ready),
    .i_x(i_x), .i_sat(i_sat), .o_valid(b_valid), .i_ready(i_ready),
    .o_y(b_y), .o_ovf(b_ovf), .i_cnt_clr(i_cnt_clr), .o_ovf_cnt(b_cnt));

  sign_narrow #(.M(32), .N(12), .CNT_W(2)) u_c (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(c_ready),
    .i_x(i_x), .i_sat(i_sat), .o_valid(c_valid), .i_ready(i_ready),
    .o_y(c_y), .o_ovf(c_ovf), .i_cnt_clr(i_cnt_clr), .o_ovf_cnt(c_cnt));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
  endtask

  logic [31:0] t1x [4];
  logic [11:0] t1y [4];
  logic [31:0] t2x [4];
  logic        t2s [4];
  logic [11:0] t2y [4];
  logic [31:0] r, x;
  logic [19:0] ey;
  logic        fit, sat;
  int          sx;

  initial begin
    t1x = '{32'h0000_07FF, 32'hFFFF_F800, 32'h0000_0000, 32'hFFFF_FFFF};
    t1y = '{12'h7FF, 12'h800, 12'h000, 12'hFFF};
    t2x = '{32'h0000_0800, 32'h0000_0800, 32'hFFFF_F7FF, 32'h8000_0000};
    t2s = '{1'b1, 1'b0, 1'b1, 1'b0};
    t2y = '{12'h7FF, 12'h800, 12'h800, 12'h000};

    i_rst = 1'b1; i_valid = 1'b0; i_x = '0; i_sat = 1'b0;
    i_ready = 1'b1; i_cnt_clr = 1'b0;
    step();
    step();
    // Reset state
    chk("rst_valid", a_valid, 0);
    chk("rst_y", a_y, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_cnt", a_cnt, 0);
    i_ready = 1'b0;
    #1;
    chk("rst_ready", a_ready, 1);
    i_ready = 1'b1;
    i_rst = 1'b0;

    // 1: boundary fits
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_x = t1x[i]; i_sat = 1'b1;
      step();
      chk("t1_valid", a_valid, 1);
      chk("t1_y", a_y, t1y[i]);
      chk("t1_ovf", a_ovf, 0);
    end
    i_valid = 1'b0;
    step();
    chk("t1_drain", a_valid, 0);
    chk("t1_cnt", a_cnt, 0);

    // 2: overflow, saturate vs wrap
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_x = t2x[i]; i_sat = t2s[i];
      step();
      chk("t2_y", a_y, t2y[i]);
      chk("t2_ovf", a_ovf, 1);
    end
    i_valid = 1'b0;
    step();
    chk("t2_cnt", a_cnt, 4);

    // 3: backpressure, words A B C
    i_ready = 1'b0; i_sat = 1'b1;
    i_valid = 1'b1; i_x = 32'h0000_0011;
    #1;
    chk("t3_ready_empty", a_ready, 1);
    step();
    chk("t3_yA", a_y, 12'h011);
    i_x = 32'h0000_0022;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t3_ready_lo", a_ready, 0);
      chk("t3_hold_valid", a_valid, 1);
      chk("t3_hold_y", a_y, 12'h011);
      step();
    end
    i_ready = 1'b1;
    #1;
    chk("t3_ready_hi", a_ready, 1);
    step();
    chk("t3_yB", a_y, 12'h022);
    i_x = 32'h0000_0033;
    step();
    chk("t3_yC", a_y, 12'h033);
    i_valid = 1'b0;
    step();
    chk("t3_empty", a_valid, 0);

    // 4: counter saturation and clear priority
    do_reset();
    i_valid = 1'b1; i_x = 32'h0000_0800; i_sat = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("t4_c_sat", c_cnt, 3);
    chk("t4_a_cnt", a_cnt, 5);
    i_cnt_clr = 1'b1;
    step();
    chk("t4_c_clr", c_cnt, 0);
    chk("t4_a_clr", a_cnt, 0);
    chk("t4_clr_ovf", a_ovf, 1);
    i_cnt_clr = 1'b0;
    step();
    chk("t4_c_after", c_cnt, 1);
    i_valid = 1'b0;
    step();

    // 5: N=20 directed
    i_valid = 1'b1; i_sat = 1'b1; i_x = 32'h0007_FFFF;
    step();
    chk("t5_y0", b_y, 20'h7FFFF);
    chk("t5_ovf0", b_ovf, 0);
    i_x = 32'h0008_0000;
    step();
    chk("t5_y1", b_y, 20'h7FFFF);
    chk("t5_ovf1", b_ovf, 1);
    i_x = 32'hFFF8_0000;
    step();
    chk("t5_y2", b_y, 20'h80000);
    chk("t5_ovf2", b_ovf, 0);

    // 5: N=20 random against a range-based model
    for (int k = 0; k < 200; k++) begin
      r = $urandom;
      x = ($urandom_range(1) == 1) ? {{12{r[19]}}, r[19:0]} : $urandom;
      sat = 1'($urandom_range(1));
      i_x = x; i_sat = sat;
      step();
      sx = $signed(x);
      fit = (sx >= -524288) && (sx <= 524287);
      chk("t5_rnd_ovf", b_ovf, !fit);
      if (fit) chk("t5_rnd_sext", {{12{b_y[19]}}, b_y}, x);
      else begin
        ey = x[19:0];
        if (sat) ey = x[31] ? 20'h80000 : 20'h7FFFF;
        chk("t5_rnd_y", b_y, ey);
      end
    end
    i_valid = 1'b0;
    step();

    // 6: reset mid-stream with a held overflowing word
    i_ready = 1'b0; i_valid = 1'b1; i_x = 32'h0000_0900; i_sat = 1'b0;
    step();
    chk("t6_held", a_valid, 1);
    chk("t6_cnt_pre", (a_cnt != 0), 1);
    i_rst = 1'b1; i_x = 32'h0000_0055;
    step();
    chk("t6_valid", a_valid, 0);
    chk("t6_y", a_y, 0);
    chk("t6_ovf", a_ovf, 0);
    chk("t6_cnt", a_cnt, 0);
    chk("t6_ready", a_ready, 1);
    i_rst = 1'b0; i_x = 32'h0000_0123;
    step();
    chk("t6_post_valid", a_valid, 1);
    chk("t6_post_y", a_y, 12'h123);
    i_valid = 1'b0; i_ready = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sign_narrow.md
# sign_narrow

Streaming signed narrowing stage: the inverse of sign extension. It accepts M-bit two's-complement words and produces N-bit words, either saturated to the N-bit range or wrapped by truncation. Every word that does not fit is flagged, and overflows are counted. It sits between a 32-bit datapath and narrow consumers such as 12-bit or 20-bit immediate/offset fields, and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- M, 32, input width (bits); M > N.
- N, 12, output width (bits); N ≥ 2.
- CNT_W, 16, overflow counter width.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  input word present.
- o_ready  out  1  block can accept a word this cycle.
- i_x  in  M  signed input word.
- i_sat  in  1  mode, sampled with the word: 1 = saturate, 0 = wrap.
- o_valid  out  1  output word present.
- i_ready  in  1  consumer accepts the output this cycle.
- o_y  out  N  narrowed signed word.
- o_ovf  out  1  the current o_y came from an input that did not fit.
- i_cnt_clr  in  1  clear the overflow counter.
- o_ovf_cnt  out  CNT_W  saturating count of accepted overflowing words.

## Operation
- **Fit rule:** i_x fits iff bits i_x[M-1:N-1] are all equal (all 0 or all 1).
- **Result, fit:** o_y = i_x[N-1:0], o_ovf = 0.
- **Result, no fit, i_sat=1:**
  - i_x[M-1]=0 → o_y = 0 followed by N-1 ones (MAX).
  - i_x[M-1]=1 → o_y = 1 followed by N-1 zeros (MIN).
- **Result, no fit, i_sat=0:** o_y = i_x[N-1:0].
- In both no-fit cases o_ovf = 1.
- **Output register:** a single entry holding o_y/o_ovf, with state EMPTY (o_valid=0) or FULL (o_valid=1).
  - EMPTY → FULL on accept.
  - FULL → EMPTY on i_ready without a new accept.
  - FULL stays FULL on i_ready with a new accept, loading the new word.
  - FULL stays FULL on no i_ready, holding the word.
- **Stability:** while o_valid=1 and i_ready=0, o_y and o_ovf are held unchanged.
- **Counter:**
  - Increments by 1 on each accept with an overflowing word.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - i_cnt_clr sets it to 0; clear wins over a same-cycle increment.
- **Reset values:** o_valid=0, o_y=0, o_ovf=0, o_ovf_cnt=0.
  - o_ready=1 after reset, because the register is EMPTY.

## Timing
- o_ready = !o_valid | i_ready. This is combinational from i_ready; there is no other combinational input-to-output path.
- Accept happens when i_valid & o_ready at a rising edge. i_x and i_sat are sampled at that edge.
- Latency is 1 cycle: o_y appears, with o_valid=1, in the cycle after accept.
- Full throughput is 1 word/cycle while i_ready is held high.
- Output transfer happens when o_valid & i_ready at an edge.
- Input side must not drop a presented word: once i_valid=1 with o_ready=0, the source keeps i_x stable. The block does not check this.
- Reset mid-operation: a word held in the output register is discarded, and o_valid=0 in the cycle after the i_rst edge.
  - An input presented during reset is not accepted.
  - The counter clears.
- i_cnt_clr takes effect at the next edge, independent of the handshake.

## Structure
- Shared package sign_pkg holds:
  - functions sat_max(N) and sat_min(N) (N-bit constants);
  - the fit-check function, reusable by sign_ext callers.
- One combinational sub-module, sign_fit_chk (params M, N):
  - inputs i_x and i_sat;
  - outputs the narrowed value and the overflow bit.
- The top level contains only the output register, the handshake and the counter.
- Instantiate and verify for both (M,N) = (32,12) and (32,20), matching the existing sign_ext configurations.

## Test plan
Parameters for 1–4 and 6 are M=32, N=12, with i_ready=1 unless stated.

1. **Boundary fits.** Inputs 0x000007FF, 0xFFFFF800, 0x00000000, 0xFFFFFFFF with i_sat=1 → o_y = 0x7FF, 0x800, 0x000, 0xFFF, each with o_ovf=0, one cycle after accept; o_ovf_cnt stays 0.
2. **Overflow, saturate vs wrap.**
   - 0x00000800 with i_sat=1 → 0x7FF, ovf=1.
   - 0x00000800 with i_sat=0 → 0x800, ovf=1.
   - 0xFFFFF7FF with i_sat=1 → 0x800, ovf=1.
   - 0x80000000 with i_sat=0 → 0x000, ovf=1.
   - o_ovf_cnt = 4 afterwards.
3. **Backpressure.** Send 3 back-to-back words with i_ready=0 for 4 cycles.
   - First word held stable on o_y.
   - o_ready=0 from the second cycle.
   - After i_ready rises, words drain in order with no loss or duplication.
4. **Counter.**
   - Set CNT_W=2 and send 5 overflowing words → o_ovf_cnt = 3, saturated.
   - Assert i_cnt_clr in the same cycle as an overflow accept → o_ovf_cnt = 0 next cycle.
5. **N=20.**
   - 0x0007FFFF → 0x7FFFF, ovf=0.
   - 0x00080000 with i_sat=1 → 0x7FFFF, ovf=1.
   - 0xFFF80000 → 0x80000, ovf=0.
   - Then 200 random words checked against a reference model: sign-extend o_y back to 32 bits and compare with i_x when ovf=0.
6. **Reset mid-stream.** Assert i_rst while o_valid=1 and i_ready=0.
   - Next cycle: o_valid=0, o_y=0, o_ovf_cnt=0, o_ready=1.
   - The first post-reset word has latency 1.
